multiboot_icap: RTL and testbench

Register-driven warm-boot engine for the golden image. It consumes the register write strobe produced by the user SPI slave (`reg_wr_en` / `reg_wr_addr` / `reg_wr_data` on `reg_clk`) and latches a 32-bit flash boot address. On a keyed command it waits a fixed delay, then drives the 8-word 7-series IPROG sequence into an ICAPE2 primitive, which reboots the FPGA into the update image.

---
 rtl/multiboot_icap.sv | 144 ++++++++++++++
 tb/tb_multiboot_icap.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiboot_icap.sv
// multiboot_icap: register-driven warm-boot engine. Latches a 32-bit flash
// boot address from the user register write port and, on a keyed command,
// waits a fixed delay and then plays the 8-word 7-series IPROG sequence
// into an ICAPE2 primitive.
module multiboot_icap #(
    parameter logic [7:0]  WREG_ADDR_L = 8'h10,
    parameter logic [7:0]  WREG_ADDR_H = 8'h11,
    parameter logic [7:0]  WREG_CMD    = 8'h12,
    parameter logic [15:0] CMD_KEY     = 16'hB007,
    parameter int          G_DELAY     = 1250,
    parameter int          G_BITSWAP   = 1
) (
    input  logic        reg_clk,
    input  logic        rst_n,
    input  logic        reg_wr_en,
    input  logic [7:0]  reg_wr_addr,
    input  logic [15:0] reg_wr_data,
    output logic [31:0] boot_addr,
    output logic        busy,
    output logic        cmd_err,
    output logic        icap_csib,
    output logic        icap_rdwrb,
    output logic [31:0] icap_o
);

    // Counter only needs to hold G_DELAY-1; keep at least one bit so a
    // zero or unit delay still elaborates cleanly.
    localparam int CW = (G_DELAY < 2) ? 1 : $clog2(G_DELAY);
    localparam logic [CW-1:0] DLY_LOAD = CW'((G_DELAY > 0) ? (G_DELAY - 1) : 0);
    localparam logic [31:0] IDLE_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_SEQ,
        ST_HOLD
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    k_q;
    logic [31:0]   boot_addr_q;
    logic          busy_q;
    logic          cmd_err_q;
    logic          csib_q;
    logic          rdwrb_q;
    logic [31:0]   icap_q;

    logic [31:0]   word_d;
    logic [31:0]   word_sw_d;
    logic [31:0]   icap_d;

    // IPROG word table; the boot address slot reads the frozen latch.
    always_comb begin
        word_d = IDLE_WORD;
        case (k_q)
            3'd0:    word_d = 32'hFFFF_FFFF;
            3'd1:    word_d = 32'hAA99_5566;
            3'd2:    word_d = 32'h2000_0000;
            3'd3:    word_d = 32'h3002_0001;
            3'd4:    word_d = boot_addr_q;
            3'd5:    word_d = 32'h3000_8001;
            3'd6:    word_d = 32'h0000_000F;
            default: word_d = 32'h2000_0000;
        endcase
    end

    // ICAPE2 expects each byte bit-reversed relative to the bitstream order.
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        for (genvar gj = 0; gj < 8; gj++) begin : g_bit
            assign word_sw_d[8*gi+gj] = word_d[8*gi+7-gj];
        end
    end

    assign icap_d = (G_BITSWAP != 0) ? word_sw_d : word_d;

    // Control FSM with registered outputs; writes are only honoured in IDLE.
    always_ff @(posedge reg_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            boot_addr_q <= '0;
            busy_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
            csib_q      <= 1'b1;
            rdwrb_q     <= 1'b0;
            icap_q      <= IDLE_WORD;
        end else begin
            rdwrb_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (reg_wr_en) begin
                        if (reg_wr_addr == WREG_ADDR_L) begin
                            boot_addr_q[15:0] <= reg_wr_data;
                        end else if (reg_wr_addr == WREG_ADDR_H) begin
                            boot_addr_q[31:16] <= reg_wr_data;
                        end else if (reg_wr_addr == WREG_CMD) begin
                            if (reg_wr_data == CMD_KEY) begin
                                cmd_err_q <= 1'b0;
                                busy_q    <= 1'b1;
                                cnt_q     <= DLY_LOAD;
                                k_q       <= '0;
                                state_q   <= (G_DELAY == 0) ? ST_SEQ : ST_DELAY;
                            end else begin
                                cmd_err_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == '0) begin
                        k_q     <= '0;
                        state_q <= ST_SEQ;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_SEQ: begin
                    csib_q <= 1'b0;
                    icap_q <= icap_d;
                    if (k_q == 3'd7) begin
                        state_q <= ST_HOLD;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: begin
                    // HOLD: bus released, busy kept until the device reconfigures.
                    csib_q <= 1'b1;
                    icap_q <= IDLE_WORD;
                end
            endcase
        end
    end

    assign boot_addr  = boot_addr_q;
    assign busy       = busy_q;
    assign cmd_err    = cmd_err_q;
    assign icap_csib  = csib_q;
    assign icap_rdwrb = rdwrb_q;
    assign icap_o     = icap_q;

endmodule

// File: tb/tb_multiboot_icap.sv
// Bench for multiboot_icap: three instances share one stimulus stream and
// differ only in delay / bit-swap parameters; a word-table model predicts
// each instance's CSIB burst timing and contents.
module tb_multiboot_icap;

    localparam int NDUT = 3;
    localparam int DLY [NDUT] = '{4, 4, 0};
    localparam int SWP [NDUT] = '{0, 1, 0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;

    logic [31:0] ba    [NDUT];
    logic        bsy   [NDUT];
    logic        err   [NDUT];
    logic        csib  [NDUT];
    logic        rdwrb [NDUT];
    logic [31:0] io    [NDUT];

    int checks = 0;
    int errors = 0;

    logic [31:0] m_addr;
    logic        m_err;

    always #5 clk = ~clk;

    multiboot_icap #(.G_DELAY(4), .G_BITSWAP(0)) dut_a (
        .reg_clk(clk), .rst_n(rst_n), .reg_wr_en(wr_en), .reg_wr_addr(wr_addr),
        .reg_wr_data(wr_data), .boot_addr(ba[0]), .busy(bsy[0]), .cmd_err(err[0]),
        .icap_csib(csib[0]), .icap_rdwrb(rdwrb[0]), .icap_o(io[0]));

    multiboot_icap #(.G_DELAY(4), .G_BITSWAP(1)) dut_b (
        .reg_clk(clk), .rst_n(rst_n), .reg_wr_en(wr_en), .reg_wr_addr(wr_addr),
        .reg_wr_data(wr_data), .boot_addr(ba[1]), .busy(bsy[1]), .cmd_err(err[1]),
        .icap_csib(csib[1]), .icap_rdwrb(rdwrb[1]), .icap_o(io[1]));

    multiboot_icap #(.G_DELAY(0), .G_BITSWAP(0)) dut_c (
        .reg_clk(clk), .rst_n(rst_n), .reg_wr_en(wr_en), .reg_wr_addr(wr_addr),
        .reg_wr_data(wr_data), .boot_addr(ba[2]), .busy(bsy[2]), .cmd_err(err[2]),
        .icap_csib(csib[2]), .icap_rdwrb(rdwrb[2]), .icap_o(io[2]));

    // Reference IPROG word k, optionally with every byte bit-reversed.
    function automatic logic [31:0] exp_word(input int k, input logic [31:0] addr, input bit swap);
        logic [31:0] w;
        logic [31:0] r;
        case (k)
            0:       w = 32'hFFFFFFFF;
            1:       w = 32'hAA995566;
            2:       w = 32'h20000000;
            3:       w = 32'h30020001;
            4:       w = addr;
            5:       w = 32'h30008001;
            6:       w = 32'h0000000F;
            default: w = 32'h20000000;
        endcase
        r = w;
        if (swap)
            for (int n = 0; n < 4; n++)
                for (int b = 0; b < 8; b++)
                    r[8*n+b] = w[8*n+7-b];
        return r;
    endfunction

    // One register write; returns at the negedge after the sampling edge.
    task automatic write_reg(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (a == 8'h10) m_addr[15:0] = d;
        else if (a == 8'h11) m_addr[31:16] = d;
        else if (a == 8'h12) m_err = (d != 16'hB007);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_addr = '0;
        m_err = 1'b0;
    endtask

    task automatic test_reset();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (ba[d] !== 32'h0 || bsy[d] !== 1'b0 || err[d] !== 1'b0 || csib[d] !== 1'b1 ||
                rdwrb[d] !== 1'b0 || io[d] !== 32'hFFFFFFFF) begin
                errors++;
                $display("FAIL reset dut%0d: got ba=%h busy=%b err=%b csib=%b rdwrb=%b io=%h, want 0/0/0/1/0/ffffffff",
                         d, ba[d], bsy[d], err[d], csib[d], rdwrb[d], io[d]);
            end
        end
        rst_n = 1'b1;
        m_addr = '0;
        m_err = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (bsy[d] !== 1'b0 || csib[d] !== 1'b1 || ba[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_idle dut%0d: got busy=%b csib=%b ba=%h, want 0/1/0", d, bsy[d], csib[d], ba[d]);
            end
        end
        $display("reset done");
    endtask

    task automatic test_addr_load();
        logic [7:0]  a;
        logic [15:0] dat;
        write_reg(8'h10, 16'h1000);
        write_reg(8'h11, 16'h0040);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (ba[d] !== 32'h00401000) begin
                errors++;
                $display("FAIL addr_load dut%0d: got %h want 00401000", d, ba[d]);
            end
        end
        $display("addr load 00401000");
        for (int t = 0; t < 8; t++) begin
            case ($urandom_range(0, 2))
                0:       a = 8'h10;
                1:       a = 8'h11;
                default: a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(8'h13, 8'hFF)) : 8'($urandom_range(0, 8'h0F));
            endcase
            dat = 16'($urandom);
            write_reg(a, dat);
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (ba[d] !== m_addr || err[d] !== 1'b0 || bsy[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL addr_rand dut%0d a=%h: got ba=%h err=%b busy=%b, want ba=%h err=0 busy=0",
                             d, a, ba[d], err[d], bsy[d], m_addr);
                end
            end
            $display("write a=%h d=%h model_addr=%h", a, dat, m_addr);
        end
    endtask

    task automatic test_wrong_key();
        logic [15:0] bad;
        for (int t = 0; t < 3; t++) begin
            if (t == 0) bad = 16'h1234;
            else begin
                bad = 16'($urandom);
                if (bad == 16'hB007) bad = 16'hB006;
            end
            write_reg(8'h12, bad);
            repeat (3) @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (err[d] !== 1'b1 || bsy[d] !== 1'b0 || csib[d] !== 1'b1 || ba[d] !== m_addr) begin
                    errors++;
                    $display("FAIL wrong_key dut%0d d=%h: got err=%b busy=%b csib=%b ba=%h, want 1/0/1/%h",
                             d, bad, err[d], bsy[d], csib[d], ba[d], m_addr);
                end
            end
            $display("wrong key %h", bad);
        end
    endtask

    // Full keyed boot; optional register writes during the wait must be ignored.
    task automatic test_sequence(input logic [31:0] addr, input bit lockout);
        int low_cnt [NDUT];
        bit exp_low;
        logic [31:0] exp;
        write_reg(8'h10, addr[15:0]);
        write_reg(8'h11, addr[31:16]);
        for (int d = 0; d < NDUT; d++) begin
            low_cnt[d] = 0;
            checks++;
            if (ba[d] !== addr) begin
                errors++;
                $display("FAIL seq_addr dut%0d: got %h want %h", d, ba[d], addr);
            end
        end
        write_reg(8'h12, 16'hB007);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (bsy[d] !== 1'b1 || err[d] !== 1'b0 || csib[d] !== 1'b1) begin
                errors++;
                $display("FAIL seq_start dut%0d: got busy=%b err=%b csib=%b, want 1/0/1", d, bsy[d], err[d], csib[d]);
            end
        end
        for (int i = 1; i <= 20; i++) begin
            wr_en = lockout && (i <= 3);
            wr_addr = (i == 1) ? 8'h10 : (i == 2) ? 8'h12 : 8'h11;
            wr_data = (i == 2) ? 16'hB007 : 16'hFFFF;
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                exp_low = (i >= DLY[d] + 1) && (i <= DLY[d] + 8);
                exp = exp_low ? exp_word(i - DLY[d] - 1, addr, SWP[d] != 0) : 32'hFFFFFFFF;
                if (csib[d] === 1'b0) low_cnt[d]++;
                checks++;
                if (csib[d] !== !exp_low || io[d] !== exp || bsy[d] !== 1'b1 || ba[d] !== addr ||
                    rdwrb[d] !== 1'b0 || err[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL seq_word dut%0d cyc%0d: got csib=%b io=%h busy=%b ba=%h rdwrb=%b err=%b, want csib=%b io=%h busy=1 ba=%h rdwrb=0 err=0",
                             d, i, csib[d], io[d], bsy[d], ba[d], rdwrb[d], err[d], !exp_low, exp, addr);
                end
            end
        end
        wr_en = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (low_cnt[d] != 8) begin
                errors++;
                $display("FAIL seq_burst_len dut%0d: got %0d want 8", d, low_cnt[d]);
            end
        end
        $display("sequence addr=%h lockout=%0d", addr, lockout);
    endtask

    task automatic test_reset_mid_seq();
        logic [31:0] addr;
        logic [31:0] exp;
        addr = $urandom;
        apply_reset();
        write_reg(8'h10, addr[15:0]);
        write_reg(8'h11, addr[31:16]);
        write_reg(8'h12, 16'hB007);
        repeat (DLY[0] + 4) @(negedge clk);
        exp = exp_word(3, addr, 1'b0);
        checks++;
        if (io[0] !== exp || csib[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_seq_k3 dut0: got io=%h csib=%b want io=%h csib=0", io[0], csib[0], exp);
        end
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (csib[d] !== 1'b1 || bsy[d] !== 1'b0 || ba[d] !== 32'h0 || io[d] !== 32'hFFFFFFFF) begin
                errors++;
                $display("FAIL async_reset dut%0d: got csib=%b busy=%b ba=%h io=%h, want 1/0/0/ffffffff",
                         d, csib[d], bsy[d], ba[d], io[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_addr = '0;
        m_err = 1'b0;
        $display("reset mid-sequence addr=%h", addr);
        test_sequence($urandom, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 2; t++) begin
            apply_reset();
            test_sequence($urandom, $urandom_range(0, 1) != 0);
        end
    endtask

    initial begin
        m_addr = '0;
        m_err = 1'b0;
        test_reset();
        test_addr_load();
        test_wrong_key();
        test_sequence(32'h00401000, 1'b0);
        apply_reset();
        test_sequence(32'h00401000, 1'b1);
        test_reset_mid_seq();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
